// File: rtl/rob_pkg.sv
// Shared reorder-buffer constants and types, used by the commit controller
// and by the ROB data array.
package rob_pkg;
    localparam int ROB_S_INDEX = 5;
    localparam int ROB_DEPTH   = 2 ** ROB_S_INDEX;
    localparam int RD_W        = 5;
    localparam int DATA_W      = 32;

    typedef logic [ROB_S_INDEX-1:0] rob_idx_t;
    typedef logic [ROB_S_INDEX:0]   cnt_t;
    typedef logic [RD_W-1:0]        rd_t;
    typedef logic [DATA_W-1:0]      word_t;

    localparam cnt_t ROB_FULL = cnt_t'(ROB_DEPTH);

    // Retire stage: launched entry waiting for its data-array read.
    typedef struct packed {
        logic     valid;
        rob_idx_t idx;
        rd_t      rd;
    } s2_t;
endpackage

// File: rtl/rob_commit_ctrl_if.sv
// Dispatch, data-array and register-file signals of the ROB commit controller.
interface rob_commit_ctrl_if;
    import rob_pkg::*;

    logic     alloc_valid;
    rd_t      alloc_rd;
    logic     alloc_ready;
    rob_idx_t alloc_idx;
    logic     head_done;
    logic     rf_stall;
    logic     rob_read;
    rob_idx_t rob_rindex;
    word_t    rob_dataout;
    logic     commit_valid;
    rd_t      commit_rd;
    word_t    commit_value;
    rob_idx_t commit_idx;
    logic     flush;
    cnt_t     count;

    modport master (
        output alloc_valid, alloc_rd, head_done, rf_stall, rob_dataout, flush,
        input  alloc_ready, alloc_idx, rob_read, rob_rindex,
               commit_valid, commit_rd, commit_value, commit_idx, count
    );

    modport slave (
        input  alloc_valid, alloc_rd, head_done, rf_stall, rob_dataout, flush,
        output alloc_ready, alloc_idx, rob_read, rob_rindex,
               commit_valid, commit_rd, commit_value, commit_idx, count
    );
endinterface

// File: rtl/rob_rd_table.sv
// Destination-register table: one synchronous write, one combinational read.
module rob_rd_table
    import rob_pkg::*;
(
    input  logic     clk_i,
    input  logic     we_i,
    input  rob_idx_t waddr_i,
    input  rd_t      wdata_i,
    input  rob_idx_t raddr_i,
    output rd_t      rdata_o
);
    rd_t mem_q [ROB_DEPTH];

    // Contents are don't-care until allocated, so the array is not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/rob_commit_ctrl.sv
// ROB head/tail pointers and in-order commit sequencer; the retired rd/value
// pair is presented one cycle after the data-array read is launched.
module rob_commit_ctrl
    import rob_pkg::*;
(
    input logic              clk_i,
    input logic              rst_ni,
    rob_commit_ctrl_if.slave bus
);
    rob_idx_t head_q, head_d, tail_q, tail_d;
    cnt_t     count_q, count_d;
    s2_t      s2_q, s2_d;
    rd_t      head_rd;
    logic     alloc_fire, launch;

    assign bus.alloc_ready = (count_q != ROB_FULL);
    assign bus.alloc_idx   = tail_q;
    assign alloc_fire      = bus.alloc_valid & bus.alloc_ready & ~bus.flush;
    assign launch          = bus.head_done & (count_q != '0) & ~bus.rf_stall & ~bus.flush;
    assign bus.rob_read    = launch;
    assign bus.rob_rindex  = head_q;

    assign bus.commit_valid = s2_q.valid;
    assign bus.commit_idx   = s2_q.idx;
    assign bus.commit_rd    = s2_q.rd;
    assign bus.commit_value = bus.rob_dataout;
    assign bus.count        = count_q;

    rob_rd_table u_rd_table (
        .clk_i   (clk_i),
        .we_i    (alloc_fire),
        .waddr_i (tail_q),
        .wdata_i (bus.alloc_rd),
        .raddr_i (head_q),
        .rdata_o (head_rd)
    );

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (launch)     head_d = head_q + 1'b1;
            if (alloc_fire) tail_d = tail_q + 1'b1;
            if (alloc_fire && !launch)      count_d = count_q + 1'b1;
            else if (launch && !alloc_fire) count_d = count_q - 1'b1;
        end
    end

    // A flush never kills s2: that entry is older than the flush point.
    always_comb begin
        s2_d       = s2_q;
        s2_d.valid = launch;
        if (launch) begin
            s2_d.idx = head_q;
            s2_d.rd  = head_rd;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            s2_q    <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            s2_q    <= s2_d;
        end
    end
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Directed bench for rob_commit_ctrl with a registered data-array model
// returning 0x100 + index.
module tb_rob_commit_ctrl;
    import rob_pkg::*;

    logic clk_i;
    logic rst_ni;
    int   n_checks = 0;
    int   n_fail   = 0;

    rob_commit_ctrl_if bus();

    rob_commit_ctrl dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    always @(posedge clk_i) begin
        if (bus.rob_read) bus.rob_dataout <= 32'h100 + 32'(bus.rob_rindex);
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic alloc_n(input int n, input int rd_base);
        for (int i = 0; i < n; i++) begin
            bus.alloc_valid = 1'b1;
            bus.alloc_rd    = rd_t'(rd_base + i);
            step();
        end
        bus.alloc_valid = 1'b0;
    endtask

    task automatic drain_n(input int n);
        bus.head_done = 1'b1;
        repeat (n) step();
        bus.head_done = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        #12;
        n_checks++; if (bus.count !== 6'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", bus.count); end
        n_checks++; if (bus.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_alloc_ready got %b exp 1", bus.alloc_ready); end
        n_checks++; if (bus.alloc_idx !== 5'd0) begin n_fail++; $display("FAIL reset_alloc_idx got %0d exp 0", bus.alloc_idx); end
        n_checks++; if (bus.rob_read !== 1'b0) begin n_fail++; $display("FAIL reset_rob_read got %b exp 0", bus.rob_read); end
        n_checks++; if (bus.rob_rindex !== 5'd0) begin n_fail++; $display("FAIL reset_rindex got %0d exp 0", bus.rob_rindex); end
        n_checks++; if (bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_commit_valid got %b exp 0", bus.commit_valid); end
        n_checks++; if (bus.commit_rd !== 5'd0 || bus.commit_idx !== 5'd0) begin n_fail++; $display("FAIL reset_commit_fields got rd=%0d idx=%0d exp 0/0", bus.commit_rd, bus.commit_idx); end
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 32; i++) begin
            bus.alloc_valid = 1'b1;
            bus.alloc_rd    = rd_t'(i);
            #1;
            n_checks++; if (bus.alloc_idx !== 5'(i) || bus.alloc_ready !== 1'b1) begin n_fail++; $display("FAIL fill_idx[%0d] got idx=%0d rdy=%b exp idx=%0d rdy=1", i, bus.alloc_idx, bus.alloc_ready, i); end
            step();
        end
        bus.alloc_valid = 1'b0;
        #1;
        n_checks++; if (bus.alloc_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready_drop got %b exp 0", bus.alloc_ready); end
        n_checks++; if (bus.count !== 6'd32) begin n_fail++; $display("FAIL fill_count got %0d exp 32", bus.count); end
        bus.alloc_valid = 1'b1;
        step();
        bus.alloc_valid = 1'b0;
        n_checks++; if (bus.count !== 6'd32 || bus.alloc_idx !== 5'd0) begin n_fail++; $display("FAIL full_ignore got cnt=%0d idx=%0d exp 32/0", bus.count, bus.alloc_idx); end
    endtask

    task automatic test_drain();
        for (int k = 0; k < 32; k++) begin
            bus.head_done   = 1'b1;
            bus.alloc_valid = (k == 0);
            #1;
            n_checks++; if (bus.rob_read !== 1'b1 || bus.rob_rindex !== 5'(k)) begin n_fail++; $display("FAIL drain_read[%0d] got rd=%b idx=%0d exp 1/%0d", k, bus.rob_read, bus.rob_rindex, k); end
            if (k == 0) begin
                n_checks++; if (bus.alloc_ready !== 1'b0) begin n_fail++; $display("FAIL full_launch_ready got %b exp 0", bus.alloc_ready); end
            end
            step();
            bus.alloc_valid = 1'b0;
            n_checks++; if (bus.commit_valid !== 1'b1 || bus.commit_idx !== 5'(k) || bus.commit_rd !== 5'(k) || bus.commit_value !== 32'h100 + 32'(k))
                begin n_fail++; $display("FAIL drain_commit[%0d] got v=%b idx=%0d rd=%0d val=%h exp 1/%0d/%0d/%h", k, bus.commit_valid, bus.commit_idx, bus.commit_rd, bus.commit_value, k, k, 32'h100 + 32'(k)); end
            if (k == 0) begin
                n_checks++; if (bus.alloc_ready !== 1'b1 || bus.count !== 6'd31) begin n_fail++; $display("FAIL full_launch_free got rdy=%b cnt=%0d exp 1/31", bus.alloc_ready, bus.count); end
            end
        end
        #1;
        n_checks++; if (bus.count !== 6'd0) begin n_fail++; $display("FAIL drain_count got %0d exp 0", bus.count); end
        n_checks++; if (bus.rob_read !== 1'b0) begin n_fail++; $display("FAIL empty_ignore_read got %b exp 0", bus.rob_read); end
        step();
        bus.head_done = 1'b0;
        n_checks++; if (bus.commit_valid !== 1'b0 || bus.count !== 6'd0) begin n_fail++; $display("FAIL empty_ignore got v=%b cnt=%0d exp 0/0", bus.commit_valid, bus.count); end
    endtask

    task automatic test_alloc_and_launch();
        alloc_n(5, 10);
        bus.alloc_valid = 1'b1;
        bus.alloc_rd    = 5'd20;
        bus.head_done   = 1'b1;
        #1;
        n_checks++; if (bus.rob_read !== 1'b1 || bus.alloc_idx !== 5'd5) begin n_fail++; $display("FAIL same_cycle_pre got rd=%b idx=%0d exp 1/5", bus.rob_read, bus.alloc_idx); end
        step();
        bus.alloc_valid = 1'b0;
        bus.head_done   = 1'b0;
        #1;
        n_checks++; if (bus.count !== 6'd5) begin n_fail++; $display("FAIL same_cycle_count got %0d exp 5", bus.count); end
        n_checks++; if (bus.alloc_idx !== 5'd6 || bus.rob_rindex !== 5'd1) begin n_fail++; $display("FAIL same_cycle_ptrs got tail=%0d head=%0d exp 6/1", bus.alloc_idx, bus.rob_rindex); end
        n_checks++; if (bus.commit_valid !== 1'b1 || bus.commit_rd !== 5'd10 || bus.commit_value !== 32'h100) begin n_fail++; $display("FAIL same_cycle_commit got v=%b rd=%0d val=%h exp 1/10/100", bus.commit_valid, bus.commit_rd, bus.commit_value); end
        drain_n(5);
    endtask

    task automatic test_wrap();
        alloc_n(24, 0);
        drain_n(24);
        n_checks++; if (bus.rob_rindex !== 5'd30 || bus.alloc_idx !== 5'd30 || bus.count !== 6'd0) begin n_fail++; $display("FAIL wrap_setup got head=%0d tail=%0d cnt=%0d exp 30/30/0", bus.rob_rindex, bus.alloc_idx, bus.count); end
        for (int i = 0; i < 4; i++) begin
            bus.alloc_valid = 1'b1;
            bus.alloc_rd    = rd_t'(i + 1);
            #1;
            n_checks++; if (bus.alloc_idx !== 5'((30 + i) % 32)) begin n_fail++; $display("FAIL wrap_alloc[%0d] got %0d exp %0d", i, bus.alloc_idx, (30 + i) % 32); end
            step();
        end
        bus.alloc_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.head_done = 1'b1;
            step();
            n_checks++; if (bus.commit_valid !== 1'b1 || bus.commit_idx !== 5'((30 + i) % 32) || bus.commit_rd !== 5'(i + 1) || bus.commit_value !== 32'h100 + 32'((30 + i) % 32))
                begin n_fail++; $display("FAIL wrap_commit[%0d] got v=%b idx=%0d rd=%0d val=%h", i, bus.commit_valid, bus.commit_idx, bus.commit_rd, bus.commit_value); end
        end
        bus.head_done = 1'b0;
        #1;
        n_checks++; if (bus.count !== 6'd0 || bus.rob_rindex !== 5'd2 || bus.alloc_idx !== 5'd2) begin n_fail++; $display("FAIL wrap_end got cnt=%0d head=%0d tail=%0d exp 0/2/2", bus.count, bus.rob_rindex, bus.alloc_idx); end
    endtask

    task automatic test_rf_stall();
        alloc_n(3, 7);
        bus.rf_stall  = 1'b1;
        bus.head_done = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++; if (bus.rob_read !== 1'b0) begin n_fail++; $display("FAIL stall_read[%0d] got %b exp 0", i, bus.rob_read); end
            step();
            n_checks++; if (bus.rob_rindex !== 5'd2 || bus.commit_valid !== 1'b0 || bus.count !== 6'd3) begin n_fail++; $display("FAIL stall_hold[%0d] got head=%0d v=%b cnt=%0d exp 2/0/3", i, bus.rob_rindex, bus.commit_valid, bus.count); end
        end
        bus.rf_stall = 1'b0;
        #1;
        n_checks++; if (bus.rob_read !== 1'b1) begin n_fail++; $display("FAIL stall_release_read got %b exp 1", bus.rob_read); end
        step();
        bus.rf_stall = 1'b1;
        n_checks++; if (bus.commit_valid !== 1'b1 || bus.commit_idx !== 5'd2 || bus.commit_rd !== 5'd7) begin n_fail++; $display("FAIL stall_release_commit got v=%b idx=%0d rd=%0d exp 1/2/7", bus.commit_valid, bus.commit_idx, bus.commit_rd); end
        step();
        n_checks++; if (bus.commit_valid !== 1'b0 || bus.count !== 6'd2 || bus.rob_rindex !== 5'd3) begin n_fail++; $display("FAIL stall_refreeze got v=%b cnt=%0d head=%0d exp 0/2/3", bus.commit_valid, bus.count, bus.rob_rindex); end
        bus.rf_stall  = 1'b0;
        bus.head_done = 1'b0;
    endtask

    task automatic test_flush();
        alloc_n(6, 20);
        drain_n(1);
        bus.head_done   = 1'b1;
        bus.flush       = 1'b1;
        bus.alloc_valid = 1'b1;
        bus.alloc_rd    = 5'd31;
        #1;
        n_checks++; if (bus.count !== 6'd7 || bus.rob_read !== 1'b0) begin n_fail++; $display("FAIL flush_cycle got cnt=%0d read=%b exp 7/0", bus.count, bus.rob_read); end
        n_checks++; if (bus.commit_valid !== 1'b1 || bus.commit_idx !== 5'd3 || bus.commit_rd !== 5'd8 || bus.commit_value !== 32'h103) begin n_fail++; $display("FAIL flush_pending got v=%b idx=%0d rd=%0d val=%h exp 1/3/8/103", bus.commit_valid, bus.commit_idx, bus.commit_rd, bus.commit_value); end
        step();
        bus.head_done   = 1'b0;
        bus.flush       = 1'b0;
        bus.alloc_valid = 1'b0;
        #1;
        n_checks++; if (bus.count !== 6'd0 || bus.rob_rindex !== 5'd0 || bus.alloc_idx !== 5'd0) begin n_fail++; $display("FAIL flush_after got cnt=%0d head=%0d tail=%0d exp 0/0/0", bus.count, bus.rob_rindex, bus.alloc_idx); end
        n_checks++; if (bus.commit_valid !== 1'b0) begin n_fail++; $display("FAIL flush_after_commit got %b exp 0", bus.commit_valid); end
    endtask

    task automatic test_async_reset();
        alloc_n(2, 3);
        drain_n(1);
        #2;
        rst_ni = 1'b0;
        #1;
        n_checks++; if (bus.count !== 6'd0 || bus.commit_valid !== 1'b0 || bus.alloc_idx !== 5'd0 || bus.rob_rindex !== 5'd0)
            begin n_fail++; $display("FAIL async_reset got cnt=%0d v=%b tail=%0d head=%0d exp 0/0/0/0", bus.count, bus.commit_valid, bus.alloc_idx, bus.rob_rindex); end
        rst_ni = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.alloc_valid = 1'b0;
        bus.alloc_rd    = '0;
        bus.head_done   = 1'b0;
        bus.rf_stall    = 1'b0;
        bus.flush       = 1'b0;
        bus.rob_dataout = '0;
        test_reset();
        test_fill();
        test_drain();
        test_alloc_and_launch();
        test_wrap();
        test_rf_stall();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
